// File: rtl/ex_operand_stage.sv
// ex_operand_stage: ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding
// Ports: clk, reset (async active-low); id_* decoded fields from ID; stall holds the
// stage, flush inserts a bubble; exmem_*/memwb_* producer write-backs; outputs ex_valid,
// SrcA, SrcB, Operation, ex_rd, ex_regwrite, ex_store_data.
// Macro EX_WB_BYPASS_EN enables the MEM/WB write-through on the ID load.
module ex_operand_stage #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4,
  parameter int REG_ADDR      = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     id_valid,
  input  logic [REG_ADDR-1:0]      id_rs1,
  input  logic [REG_ADDR-1:0]      id_rs2,
  input  logic [DATA_WIDTH-1:0]    id_rs1_data,
  input  logic [DATA_WIDTH-1:0]    id_rs2_data,
  input  logic [DATA_WIDTH-1:0]    id_imm,
  input  logic                     id_alusrc,
  input  logic [OPCODE_LENGTH-1:0] id_operation,
  input  logic [REG_ADDR-1:0]      id_rd,
  input  logic                     id_regwrite,
  input  logic                     stall,
  input  logic                     flush,
  input  logic                     exmem_regwrite,
  input  logic [REG_ADDR-1:0]      exmem_rd,
  input  logic [DATA_WIDTH-1:0]    exmem_result,
  input  logic                     memwb_regwrite,
  input  logic [REG_ADDR-1:0]      memwb_rd,
  input  logic [DATA_WIDTH-1:0]    memwb_result,
  output logic                     ex_valid,
  output logic [DATA_WIDTH-1:0]    SrcA,
  output logic [DATA_WIDTH-1:0]    SrcB,
  output logic [OPCODE_LENGTH-1:0] Operation,
  output logic [REG_ADDR-1:0]      ex_rd,
  output logic                     ex_regwrite,
  output logic [DATA_WIDTH-1:0]    ex_store_data
);
  logic                     valid, alusrc, regwrite;
  logic [REG_ADDR-1:0]      rs1, rs2, rd;
  logic [DATA_WIDTH-1:0]    op_a, op_b, imm, fwd_a, fwd_b, ld_a, ld_b;
  logic [OPCODE_LENGTH-1:0] operation;
  logic                     ex_a, ex_b, wb_a, wb_b;
  always_comb begin
    ex_a  = exmem_regwrite && exmem_rd != '0 && exmem_rd == rs1;
    ex_b  = exmem_regwrite && exmem_rd != '0 && exmem_rd == rs2;
    wb_a  = memwb_regwrite && memwb_rd != '0 && memwb_rd == rs1;
    wb_b  = memwb_regwrite && memwb_rd != '0 && memwb_rd == rs2;
    fwd_a = ex_a ? exmem_result : wb_a ? memwb_result : op_a;
    fwd_b = ex_b ? exmem_result : wb_b ? memwb_result : op_b;
`ifdef EX_WB_BYPASS_EN
    ld_a  = (memwb_regwrite && memwb_rd != '0 && memwb_rd == id_rs1) ? memwb_result : id_rs1_data;
    ld_b  = (memwb_regwrite && memwb_rd != '0 && memwb_rd == id_rs2) ? memwb_result : id_rs2_data;
`else
    ld_a  = id_rs1_data;
    ld_b  = id_rs2_data;
`endif
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid     <= 1'b0;
      rs1       <= '0;
      rs2       <= '0;
      op_a      <= '0;
      op_b      <= '0;
      imm       <= '0;
      alusrc    <= 1'b0;
      operation <= '0;
      rd        <= '0;
      regwrite  <= 1'b0;
    end else if (flush) begin
      valid     <= 1'b0;
      regwrite  <= 1'b0;
      operation <= '0;
    end else if (stall) begin
      op_a      <= fwd_a;
      op_b      <= fwd_b;
    end else begin
      valid     <= id_valid;
      rs1       <= id_rs1;
      rs2       <= id_rs2;
      op_a      <= ld_a;
      op_b      <= ld_b;
      imm       <= id_imm;
      alusrc    <= id_alusrc;
      operation <= id_operation;
      rd        <= id_rd;
      regwrite  <= id_regwrite & id_valid;
    end
  end
  assign ex_valid      = valid;
  assign SrcA          = fwd_a;
  assign SrcB          = alusrc ? imm : fwd_b;
  assign ex_store_data = fwd_b;
  assign Operation     = operation;
  assign ex_rd         = rd;
  assign ex_regwrite   = regwrite & valid;
endmodule

// File: tb/tb_ex_operand_stage.sv
// tb_ex_operand_stage: randomized and directed self-checking bench for ex_operand_stage
module tb_ex_operand_stage;
  logic        clk = 0, reset = 0;
  logic        id_valid = 0, id_alusrc = 0, id_regwrite = 0, stall = 0, flush = 0;
  logic [4:0]  id_rs1 = 0, id_rs2 = 0, id_rd = 0, exmem_rd = 0, memwb_rd = 0;
  logic [31:0] id_rs1_data = 0, id_rs2_data = 0, id_imm = 0, exmem_result = 0, memwb_result = 0;
  logic [3:0]  id_operation = 0;
  logic        exmem_regwrite = 0, memwb_regwrite = 0;
  logic        ex_valid, ex_regwrite;
  logic [31:0] SrcA, SrcB, ex_store_data;
  logic [3:0]  Operation;
  logic [4:0]  ex_rd;
  int errors = 0, checks = 0;

  ex_operand_stage dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_alusrc(id_alusrc), .id_operation(id_operation), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .stall(stall), .flush(flush),
    .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .ex_valid(ex_valid), .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation), .ex_rd(ex_rd),
    .ex_regwrite(ex_regwrite), .ex_store_data(ex_store_data)
  );

  always #5 clk = ~clk;

  // Reference: the instruction currently held by the stage, plus a flag marking
  // fields that became don't-care after a flush.
  logic        m_valid, m_alusrc, m_rw, m_dc;
  logic [4:0]  m_rs1, m_rs2, m_rd;
  logic [31:0] m_a, m_b, m_imm;
  logic [3:0]  m_op;

  // Newest producer writing a nonzero register wins.
  function automatic logic [31:0] newest(input logic [4:0] r, input logic [31:0] stored);
    if (r == 0) return stored;
    if (exmem_regwrite && exmem_rd == r) return exmem_result;
    if (memwb_regwrite && memwb_rd == r) return memwb_result;
    return stored;
  endfunction

  function automatic logic [31:0] id_read(input logic [4:0] r, input logic [31:0] rf);
`ifdef EX_WB_BYPASS_EN
    if (r != 0 && memwb_regwrite && memwb_rd == r) return memwb_result;
`endif
    return rf;
  endfunction

  function automatic logic [31:0] exp_a(); return newest(m_rs1, m_a); endfunction
  function automatic logic [31:0] exp_st(); return newest(m_rs2, m_b); endfunction
  function automatic logic [31:0] exp_b(); return m_alusrc ? m_imm : newest(m_rs2, m_b); endfunction

  task automatic model_clear();
    {m_valid, m_alusrc, m_rw, m_dc} = '0;
    {m_rs1, m_rs2, m_rd} = '0;
    {m_a, m_b, m_imm} = '0;
    m_op = '0;
  endtask

  task automatic tick();
    logic [31:0] na, nb;
    na = exp_a();
    nb = exp_st();
    if (flush) begin
      m_valid = 0; m_rw = 0; m_op = 0; m_dc = 1;
    end else if (stall) begin
      m_a = na; m_b = nb;
    end else begin
      m_valid = id_valid; m_rw = id_regwrite && id_valid; m_dc = 0;
      m_rs1 = id_rs1; m_rs2 = id_rs2; m_rd = id_rd; m_imm = id_imm;
      m_alusrc = id_alusrc; m_op = id_operation;
      m_a = id_read(id_rs1, id_rs1_data);
      m_b = id_read(id_rs2, id_rs2_data);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_producers();
    exmem_regwrite = 0; memwb_regwrite = 0; exmem_rd = 0; memwb_rd = 0;
  endtask

  task automatic load(input logic [4:0] r1, input logic [31:0] d1, input logic [4:0] r2,
                      input logic [31:0] d2, input logic [3:0] op, input logic [4:0] rd);
    id_valid = 1; id_regwrite = 1; id_rs1 = r1; id_rs1_data = d1; id_rs2 = r2;
    id_rs2_data = d2; id_operation = op; id_rd = rd; id_alusrc = 0; id_imm = 0;
    stall = 0; flush = 0;
    tick();
    id_valid = 0;
  endtask

  task automatic test_reset();
    model_clear();
    #2;
    checks++; if (ex_valid !== 0) begin errors++; $display("FAIL reset_valid got=%0h want=0", ex_valid); end
    checks++; if (SrcA !== 0 || SrcB !== 0) begin errors++; $display("FAIL reset_src got=%0h/%0h want=0/0", SrcA, SrcB); end
    checks++; if (Operation !== 0 || ex_rd !== 0 || ex_regwrite !== 0 || ex_store_data !== 0) begin
      errors++; $display("FAIL reset_misc got op=%0h rd=%0h rw=%0h st=%0h want 0", Operation, ex_rd, ex_regwrite, ex_store_data); end
    @(negedge clk); reset = 1;
    idle_producers();
    load(1, 5, 2, 7, 4'b0010, 3);
    checks++; if (SrcA !== 5 || SrcB !== 7) begin errors++; $display("FAIL add_src got=%0h/%0h want=5/7", SrcA, SrcB); end
    checks++; if (Operation !== 4'b0010 || ex_valid !== 1 || ex_regwrite !== 1 || ex_rd !== 3) begin
      errors++; $display("FAIL add_ctl got op=%0h v=%0h rw=%0h rd=%0h want 2/1/1/3", Operation, ex_valid, ex_regwrite, ex_rd); end
    // Asynchronous: sampled between edges with no clock edge in between.
    #2 reset = 0; #1;
    model_clear();
    checks++; if (ex_valid !== 0 || SrcA !== 0 || SrcB !== 0 || ex_regwrite !== 0 || Operation !== 0) begin
      errors++; $display("FAIL async_reset got v=%0h a=%0h b=%0h rw=%0h op=%0h want 0", ex_valid, SrcA, SrcB, ex_regwrite, Operation); end
    @(negedge clk); reset = 1;
    load(1, 5, 2, 7, 4'b0010, 3);
    checks++; if (SrcA !== 5 || SrcB !== 7 || Operation !== 4'b0010) begin
      errors++; $display("FAIL reload got a=%0h b=%0h op=%0h want 5/7/2", SrcA, SrcB, Operation); end
  endtask

  task automatic test_priority();
    idle_producers();
    load(4, 32'h3, 0, 0, 4'b0110, 8);
    exmem_regwrite = 1; exmem_rd = 4; exmem_result = 32'h11;
    memwb_regwrite = 1; memwb_rd = 4; memwb_result = 32'h22;
    #1;
    checks++; if (SrcA !== 32'h11) begin errors++; $display("FAIL ex_priority got=%0h want=11", SrcA); end
    exmem_regwrite = 0; #1;
    checks++; if (SrcA !== 32'h22) begin errors++; $display("FAIL wb_fwd got=%0h want=22", SrcA); end
    exmem_regwrite = 1; exmem_rd = 0; memwb_rd = 0; #1;
    checks++; if (SrcA !== 32'h3) begin errors++; $display("FAIL x0_nofwd got=%0h want=3", SrcA); end
    idle_producers();
  endtask

  task automatic test_stall();
    load(0, 0, 6, 32'h10, 4'b0000, 9);
    exmem_regwrite = 1; exmem_rd = 6; exmem_result = 32'h55; stall = 1;
    tick();
    exmem_regwrite = 0; #1;
    checks++; if (SrcB !== 32'h55 || ex_store_data !== 32'h55) begin
      errors++; $display("FAIL stall_fold got b=%0h st=%0h want 55/55", SrcB, ex_store_data); end
    tick();
    checks++; if (SrcB !== 32'h55 || ex_store_data !== 32'h55 || ex_rd !== 9) begin
      errors++; $display("FAIL stall_hold got b=%0h st=%0h rd=%0h want 55/55/9", SrcB, ex_store_data, ex_rd); end
  endtask

  task automatic test_flush();
    stall = 1; flush = 1;
    tick();
    checks++; if (ex_valid !== 0 || ex_regwrite !== 0 || Operation !== 0) begin
      errors++; $display("FAIL flush_over_stall got v=%0h rw=%0h op=%0h want 0/0/0", ex_valid, ex_regwrite, Operation); end
    stall = 0; flush = 0;
  endtask

  task automatic test_wb_bypass();
    logic [31:0] want;
    idle_producers();
    memwb_regwrite = 1; memwb_rd = 9; memwb_result = 32'hAB;
    load(9, 32'h1, 0, 0, 4'b0001, 2);
    memwb_regwrite = 0; #1;
`ifdef EX_WB_BYPASS_EN
    want = 32'hAB;
`else
    want = 32'h1;
`endif
    checks++; if (SrcA !== want) begin errors++; $display("FAIL wb_bypass got=%0h want=%0h", SrcA, want); end
  endtask

  task automatic test_imm();
    idle_producers();
    id_valid = 1; id_regwrite = 1; id_rs1 = 1; id_rs1_data = 2; id_rs2 = 12; id_rs2_data = 3;
    id_alusrc = 1; id_imm = 32'hFFFFFFFC; id_operation = 4'b0010; id_rd = 5;
    tick();
    id_valid = 0; id_alusrc = 0;
    exmem_regwrite = 1; exmem_rd = 12; exmem_result = 32'h77; #1;
    checks++; if (SrcB !== 32'hFFFFFFFC || ex_store_data !== 32'h77) begin
      errors++; $display("FAIL imm got b=%0h st=%0h want fffffffc/77", SrcB, ex_store_data); end
    idle_producers();
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      id_valid = $urandom_range(0, 3) != 0; id_regwrite = $urandom_range(0, 1);
      id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
      id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
      id_alusrc = $urandom_range(0, 1); id_operation = 4'($urandom); id_rd = 5'($urandom);
      stall = $urandom_range(0, 3) == 0; flush = $urandom_range(0, 7) == 0;
      exmem_regwrite = $urandom_range(0, 1); exmem_rd = 5'($urandom_range(0, 3)); exmem_result = $urandom;
      memwb_regwrite = $urandom_range(0, 1); memwb_rd = 5'($urandom_range(0, 3)); memwb_result = $urandom;
      tick();
      exmem_regwrite = $urandom_range(0, 1); exmem_rd = 5'($urandom_range(0, 3)); exmem_result = $urandom;
      memwb_regwrite = $urandom_range(0, 1); memwb_rd = 5'($urandom_range(0, 3)); memwb_result = $urandom;
      #1;
      checks++;
      if (ex_valid !== m_valid || ex_regwrite !== (m_valid & m_rw) || Operation !== m_op) begin
        errors++; $display("FAIL rand_ctl[%0d] got v=%0h rw=%0h op=%0h want %0h/%0h/%0h",
          i, ex_valid, ex_regwrite, Operation, m_valid, m_valid & m_rw, m_op); end
      if (!m_dc) begin
        checks++;
        if (SrcA !== exp_a() || SrcB !== exp_b() || ex_store_data !== exp_st() || ex_rd !== m_rd) begin
          errors++; $display("FAIL rand_data[%0d] got a=%0h b=%0h st=%0h rd=%0h want %0h/%0h/%0h/%0h",
            i, SrcA, SrcB, ex_store_data, ex_rd, exp_a(), exp_b(), exp_st(), m_rd); end
      end
    end
    stall = 0; flush = 0;
  endtask

  initial begin
    test_reset();
    test_priority();
    test_stall();
    test_flush();
    test_wb_bypass();
    test_imm();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ex_operand_stage.md
Name: ex_operand_stage

Overview:
- ID/EX pipeline register plus operand-forwarding unit. Sits directly upstream of the ALU and drives its SrcA, SrcB and Operation inputs.
- Captures decoded instruction fields from ID and resolves RAW hazards by forwarding from the EX/MEM and MEM/WB results.
- Holds under stall, keeping forwarded operands valid while the producers retire.
- Inserts a bubble on flush.

Parameters:
- DATA_WIDTH, 32, operand/result width.
- OPCODE_LENGTH, 4, ALU operation code width.
- REG_ADDR, 5, register index width.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- id_valid  input  1  ID slot holds a real instruction.
- id_rs1, id_rs2  input  REG_ADDR  source register indices.
- id_rs1_data, id_rs2_data  input  DATA_WIDTH  register-file read data.
- id_imm  input  DATA_WIDTH  sign-extended immediate.
- id_alusrc  input  1  1 = SrcB takes the immediate.
- id_operation  input  OPCODE_LENGTH  ALU operation code.
- id_rd  input  REG_ADDR  destination index.
- id_regwrite  input  1  instruction writes rd.
- stall  input  1  hold the stage contents.
- flush  input  1  replace the stage with a bubble.
- exmem_regwrite, exmem_rd, exmem_result  input  1/REG_ADDR/DATA_WIDTH  EX/MEM producer.
- memwb_regwrite, memwb_rd, memwb_result  input  1/REG_ADDR/DATA_WIDTH  MEM/WB producer.
- ex_valid  output  1  stage holds a real instruction.
- SrcA, SrcB  output  DATA_WIDTH  ALU operands.
- Operation  output  OPCODE_LENGTH  ALU operation code.
- ex_rd  output  REG_ADDR  destination index.
- ex_regwrite  output  1  gated by ex_valid.
- ex_store_data  output  DATA_WIDTH  forwarded rs2 value, used for stores.

Behaviour:
- Stored state: valid, rs1, rs2, op_a, op_b, imm, alusrc, operation, rd, regwrite.
- Reset (async, reset=0): all stored state cleared to 0. Outputs therefore read ex_valid=0, SrcA=SrcB=0, Operation=4'b0000, ex_rd=0, ex_regwrite=0, ex_store_data=0.
- Forwarding (combinational, on stored state):
  - fwd_a = exmem_result if exmem_regwrite && exmem_rd!=0 && exmem_rd==rs1.
  - Otherwise fwd_a = memwb_result if memwb_regwrite && memwb_rd!=0 && memwb_rd==rs1.
  - Otherwise fwd_a = op_a.
  - fwd_b is the same, using rs2/op_b.
  - EX/MEM always wins over MEM/WB. Index 0 never forwards.
- Outputs:
  - SrcA = fwd_a.
  - SrcB = alusrc ? imm : fwd_b.
  - ex_store_data = fwd_b.
  - Operation = stored operation.
  - ex_regwrite = regwrite & valid.
- Edge actions, in priority order:
  1. flush=1: valid<=0, regwrite<=0, operation<=0. Other fields are don't-care. Flush overrides stall.
  2. stall=1: all fields hold, except op_a<=fwd_a and op_b<=fwd_b. This folds forwarded values into storage so they survive producer retirement.
  3. Otherwise load from ID:
     - valid<=id_valid, regwrite<=id_regwrite&id_valid, and all other fields from the id_* ports.
     - op_a/op_b load with the WB write-through bypass: if memwb_regwrite && memwb_rd!=0 && memwb_rd==id_rs1, op_a<=memwb_result, else op_a<=id_rs1_data. op_b is the same for id_rs2.
- Latency: ID fields appear on the outputs one cycle after the loading edge. Forwarding adds no cycles.
- Bubble (valid=0) outputs still drive the muxes but ex_regwrite=0. A bubble never acts as a forwarding consumer requirement.
- Reset asserted mid-stall or mid-flush: state clears immediately. First load occurs on the first edge after release.

Optional Feature:
- Macro: EX_WB_BYPASS_EN.
- Defined: the ID-load write-through bypass is active, as above.
- Undefined: op_a<=id_rs1_data and op_b<=id_rs2_data unconditionally. Use this when the register file writes on the falling edge and already returns the new value.
- Stall-time fold-in and EX forwarding are unaffected by the macro.

Test Plan:
- Reset: reset=0 mid-run with valid=1 loaded -> all outputs 0 immediately, asynchronously; after release, load add x3,x1,x2 (x1=5, x2=7) -> next cycle SrcA=5, SrcB=7, Operation=0010.
- EX/MEM priority: stored rs1=4; exmem (rd=4, result=0x11) and memwb (rd=4, result=0x22) both writing -> SrcA=0x11. Same with exmem_rd=0 and memwb_rd=0 -> SrcA=op_a.
- Stall fold-in: rs2=6, exmem forwards 0x55 with stall=1; next cycle exmem_regwrite=0 and stall still 1 -> SrcB and ex_store_data remain 0x55.
- Flush over stall: stall=1 and flush=1 together -> next cycle ex_valid=0, ex_regwrite=0, Operation=0.
- WB bypass: id_rs1=9, id_rs1_data=0x1, memwb rd=9 result=0xAB at the load edge -> SrcA=0xAB with EX_WB_BYPASS_EN defined, 0x1 without it.
- Immediate: id_alusrc=1, id_imm=0xFFFFFFFC, rs2 forwarded 0x77 -> SrcB=0xFFFFFFFC, ex_store_data=0x77.
